// File: rtl/ternary_stream_reducer_if.sv
// Handshake bundle for ternary_stream_reducer: trit input stream plus folded result stream.
// The out_err signal exists only when TERNARY_ILLEGAL_CHECK_EN is defined.
interface ternary_stream_reducer_if #(
    parameter int MAX_LEN = 16
);
    localparam int CW = $clog2(MAX_LEN + 1);

    logic [1:0]    op;
    logic          in_valid;
    logic          in_ready;
    logic          in0;
    logic          in1;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out0;
    logic          out1;
    logic [CW-1:0] out_len;
    logic          out_trunc;
`ifdef TERNARY_ILLEGAL_CHECK_EN
    logic          out_err;

    modport master (
        output op, in_valid, in0, in1, in_last, out_ready,
        input  in_ready, out_valid, out0, out1, out_len, out_trunc, out_err
    );
    modport slave (
        input  op, in_valid, in0, in1, in_last, out_ready,
        output in_ready, out_valid, out0, out1, out_len, out_trunc, out_err
    );
`else
    modport master (
        output op, in_valid, in0, in1, in_last, out_ready,
        input  in_ready, out_valid, out0, out1, out_len, out_trunc
    );
    modport slave (
        input  op, in_valid, in0, in1, in_last, out_ready,
        output in_ready, out_valid, out0, out1, out_len, out_trunc
    );
`endif
endinterface

// File: rtl/ternary_stream_reducer.sv
// Folds a stream of two-rail trits per frame with MAX/MIN/CONSENSUS/ANY and emits one result per frame.
// Define TERNARY_ILLEGAL_CHECK_EN to flag frames containing the illegal 11 encoding on out_err.
module ternary_stream_reducer #(
    parameter int MAX_LEN = 16
) (
    input logic                    clk,
    input logic                    reset,
    ternary_stream_reducer_if.slave bus
);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    function automatic logic [1:0] fold_trit(input logic [1:0] f_op, input logic [1:0] a,
                                             input logic [1:0] b);
        logic [1:0] r;
        case (f_op)
            2'b00:   r = (a > b) ? a : b;
            2'b01:   r = (a < b) ? a : b;
            2'b10:   r = (a == b) ? a : 2'b01;
            default: begin
                if (a == b)           r = a;
                else if (a == 2'b01)  r = b;
                else if (b == 2'b01)  r = a;
                else                  r = 2'b01;
            end
        endcase
        return r;
    endfunction

    // The illegal 11 code is treated as 2 by masking rail 0.
    function automatic logic [1:0] coerce_trit(input logic r1, input logic r0);
        return r1 ? 2'b10 : {1'b0, r0};
    endfunction

    state_t        state_p0, state_next;
    logic [1:0]    acc_p0;
    logic [1:0]    op_p0;
    logic [CW-1:0] count_p0;
    logic [1:0]    out_trit_p1;
    logic [CW-1:0] out_len_p1;
    logic          out_trunc_p1;

    logic          in_ready_c, accept, load_out, trunc_next, handshake;
    logic [1:0]    trit_in, fold_res;
    logic [CW-1:0] cnt_inc;

    assign trit_in  = coerce_trit(bus.in1, bus.in0);
    assign fold_res = fold_trit(op_p0, acc_p0, trit_in);
    assign cnt_inc  = count_p0 + CW'(1);

    always_comb begin
        state_next = state_p0;
        load_out   = 1'b0;
        trunc_next = 1'b0;
        handshake  = 1'b0;
        in_ready_c = (state_p0 != OUT);
        accept     = bus.in_valid && in_ready_c;
        case (state_p0)
            IDLE: begin
                if (accept) begin
                    if (bus.in_last || (MAX_LEN == 1)) begin
                        state_next = OUT;
                        load_out   = 1'b1;
                    end else begin
                        state_next = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_next = OUT;
                        load_out   = 1'b1;
                    end else if (cnt_inc == CW'(MAX_LEN)) begin
                        state_next = OUT;
                        load_out   = 1'b1;
                        trunc_next = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                    handshake  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_p0 <= IDLE;
        else       state_p0 <= state_next;
    end

    // Stage p0: fold accumulator; stage p1: result registers that hold between frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0       <= 2'b00;
            op_p0        <= 2'b00;
            count_p0     <= '0;
            out_trit_p1  <= 2'b00;
            out_len_p1   <= '0;
            out_trunc_p1 <= 1'b0;
        end else begin
            if (accept && state_p0 == IDLE) begin
                acc_p0   <= trit_in;
                op_p0    <= bus.op;
                count_p0 <= CW'(1);
            end else if (accept && state_p0 == ACC) begin
                acc_p0   <= fold_res;
                count_p0 <= cnt_inc;
            end else if (handshake) begin
                count_p0 <= '0;
            end
            if (load_out) begin
                out_trit_p1  <= (state_p0 == IDLE) ? trit_in : fold_res;
                out_len_p1   <= (state_p0 == IDLE) ? CW'(1) : cnt_inc;
                out_trunc_p1 <= trunc_next;
            end
        end
    end

`ifdef TERNARY_ILLEGAL_CHECK_EN
    logic illegal, err_p0, out_err_p1;
    assign illegal = bus.in1 && bus.in0;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_p0     <= 1'b0;
            out_err_p1 <= 1'b0;
        end else begin
            if (accept && state_p0 == IDLE)     err_p0 <= illegal;
            else if (accept && state_p0 == ACC) err_p0 <= err_p0 | illegal;
            else if (handshake)                 err_p0 <= 1'b0;
            if (load_out)       out_err_p1 <= (state_p0 == IDLE) ? illegal : (err_p0 | illegal);
            else if (handshake) out_err_p1 <= 1'b0;
        end
    end

    assign bus.out_err = out_err_p1;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_p0 == OUT);
    assign bus.out0      = out_trit_p1[0];
    assign bus.out1      = out_trit_p1[1];
    assign bus.out_len   = out_len_p1;
    assign bus.out_trunc = out_trunc_p1;
endmodule
